roi_color_classifier: RTL

- Parametrised successor to the fixed 3-colour-plus-white ROI detector: classifies each ROI pixel into one of NUM_CLASSES runtime-programmable RGB box classes.
- Accumulates saturating per-class counts each frame and picks a frame winner with a sequential arg-max scan.
- Debounces the winner over STABLE_FRAMES consecutive frames before reporting it.
- Sits between the 320x240 RGB888 pixel reader and the game FSM; class 0 is the background (white) class.

---
 rtl/roi_color_classifier.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/roi_color_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : roi_color_classifier                                         |
// | Description : Classifies ROI pixels into NUM_CLASSES programmable RGB box  |
// |               classes, counts them per frame, picks a frame winner by a    |
// |               sequential arg-max scan and debounces it into a stable lock. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module roi_color_classifier #(
  parameter int NUM_CLASSES   = 4,
  parameter int COORD_W       = 10,
  parameter int CNT_W         = 17,
  parameter int STABLE_FRAMES = 3,
  localparam int CLS_W        = $clog2(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pixel_valid,
  input  logic                         frame_start,
  input  logic [COORD_W-1:0]           x_coord,
  input  logic [COORD_W-1:0]           y_coord,
  input  logic [7:0]                   pixel_r,
  input  logic [7:0]                   pixel_g,
  input  logic [7:0]                   pixel_b,
  input  logic [COORD_W-1:0]           roi_x_start,
  input  logic [COORD_W-1:0]           roi_x_end,
  input  logic [COORD_W-1:0]           roi_y_start,
  input  logic [COORD_W-1:0]           roi_y_end,
  input  logic [NUM_CLASSES*8-1:0]     cls_r_min,
  input  logic [NUM_CLASSES*8-1:0]     cls_r_max,
  input  logic [NUM_CLASSES*8-1:0]     cls_g_min,
  input  logic [NUM_CLASSES*8-1:0]     cls_g_max,
  input  logic [NUM_CLASSES*8-1:0]     cls_b_min,
  input  logic [NUM_CLASSES*8-1:0]     cls_b_max,
  input  logic [NUM_CLASSES*CNT_W-1:0] cls_cnt_min,
  input  logic                         clear_lock,
  output logic                         in_roi,
  output logic                         pixel_match,
  output logic [CLS_W-1:0]             pixel_class,
  output logic [CLS_W-1:0]             frame_class,
  output logic                         frame_none,
  output logic                         frame_valid,
  output logic [CNT_W-1:0]             frame_count,
  output logic [CLS_W-1:0]             stable_class,
  output logic                         stable_locked,
  output logic                         change_event,
  output logic                         overrun_err
);

  // Scan index needs one extra bit so it can reach NUM_CLASSES (fallback step)
  localparam int                 IDX_W      = CLS_W + 1;
  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(NUM_CLASSES);
  localparam logic [3:0]         C_STABLE   = 4'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0]   C_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [NUM_CLASSES-1:0] w_match;
  logic [CNT_W-1:0]       w_cnt_min [NUM_CLASSES];
  logic [CNT_W-1:0]       r_cnt     [NUM_CLASSES];
  logic [CNT_W-1:0]       r_snap    [NUM_CLASSES];
  logic                   w_in_roi;
  logic                   w_any_match;
  logic [CLS_W-1:0]       w_pix_class;
  logic                   w_edge;
  logic                   r_fs_d;
  logic                   r_first;
  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [CLS_W-1:0]       r_best_idx;
  logic [CNT_W-1:0]       r_best_cnt;
  logic                   r_best_found;
  logic [CNT_W-1:0]       w_scan_cnt;
  logic [CNT_W-1:0]       w_scan_min;
  logic [CLS_W-1:0]       r_cand;
  logic                   r_cand_none;
  logic [3:0]             r_run;
  logic                   w_res_none;
  logic [CLS_W-1:0]       w_res_class;
  logic                   w_same;
  logic [3:0]             w_run_next;
  logic                   w_lock_now;

  // Per-class colour box match and threshold unpacking
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
    assign w_match[k] = (pixel_r >= cls_r_min[8*k +: 8]) && (pixel_r <= cls_r_max[8*k +: 8]) &&
                        (pixel_g >= cls_g_min[8*k +: 8]) && (pixel_g <= cls_g_max[8*k +: 8]) &&
                        (pixel_b >= cls_b_min[8*k +: 8]) && (pixel_b <= cls_b_max[8*k +: 8]);
    assign w_cnt_min[k] = cls_cnt_min[CNT_W*k +: CNT_W];
  end

  // Priority encode the matching classes, lowest index wins
  always_comb begin
    w_pix_class = '0;
    w_any_match = 1'b0;
    for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_pix_class = CLS_W'(k);
        w_any_match = 1'b1;
      end
    end
  end

  assign w_in_roi    = (x_coord >= roi_x_start) && (x_coord < roi_x_end) &&
                       (y_coord >= roi_y_start) && (y_coord < roi_y_end);
  assign in_roi      = w_in_roi;
  assign pixel_match = w_in_roi && pixel_valid && w_any_match;
  assign pixel_class = w_pix_class;
  assign w_edge      = frame_start && !r_fs_d;

  assign w_scan_cnt  = r_snap[r_idx[CLS_W-1:0]];
  assign w_scan_min  = w_cnt_min[r_idx[CLS_W-1:0]];

  // Debounce: compare this frame's result with the running candidate
  assign w_res_none  = !r_best_found;
  assign w_res_class = r_best_found ? r_best_idx : '0;
  assign w_same      = (w_res_none == r_cand_none) && (w_res_none || (w_res_class == r_cand));
  assign w_run_next  = w_same ? ((r_run < C_STABLE) ? r_run + 4'd1 : C_STABLE) : 4'd1;
  assign w_lock_now  = (w_run_next == C_STABLE) && !w_res_none &&
                       (!stable_locked || (w_res_class != stable_class));

  // Per-class saturating counters; the frame edge snapshots and clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_cnt[k]  <= '0;
        r_snap[k] <= '0;
      end
    end else if (w_edge) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_snap[k] <= r_cnt[k];
        r_cnt[k]  <= '0;
      end
    end else if (pixel_match && (r_cnt[w_pix_class] != C_CNT_MAX)) begin
      r_cnt[w_pix_class] <= r_cnt[w_pix_class] + CNT_W'(1);
    end
  end

  // Frame FSM: arg-max scan, result registration, debounce and lock handling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_first       <= 1'b1;
      r_fs_d        <= 1'b0;
      r_idx         <= '0;
      r_best_idx    <= '0;
      r_best_cnt    <= '0;
      r_best_found  <= 1'b0;
      r_cand        <= '0;
      r_cand_none   <= 1'b0;
      r_run         <= '0;
      frame_class   <= '0;
      frame_none    <= 1'b0;
      frame_valid   <= 1'b0;
      frame_count   <= '0;
      stable_class  <= '0;
      stable_locked <= 1'b0;
      change_event  <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      r_fs_d       <= frame_start;
      frame_valid  <= 1'b0;
      change_event <= 1'b0;
      if (w_edge) begin
        // A new edge always wins: an in-flight evaluation is abandoned
        if (r_state != S_IDLE) begin
          overrun_err <= 1'b1;
        end
        if (r_first) begin
          r_first <= 1'b0;
        end else begin
          r_state      <= S_EVAL;
          r_idx        <= IDX_W'(1);
          r_best_found <= 1'b0;
          r_best_idx   <= '0;
          r_best_cnt   <= '0;
        end
      end else begin
        case (r_state)
          S_EVAL: begin
            if (r_idx == C_LAST_IDX) begin
              // Background only wins when no foreground class qualified
              if (!r_best_found && (r_snap[0] > w_cnt_min[0])) begin
                r_best_found <= 1'b1;
                r_best_idx   <= '0;
                r_best_cnt   <= r_snap[0];
              end
              r_state <= S_DONE;
            end else begin
              if ((w_scan_cnt > w_scan_min) && (!r_best_found || (w_scan_cnt > r_best_cnt))) begin
                r_best_found <= 1'b1;
                r_best_idx   <= r_idx[CLS_W-1:0];
                r_best_cnt   <= w_scan_cnt;
              end
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          S_DONE: begin
            frame_valid <= 1'b1;
            frame_none  <= w_res_none;
            frame_class <= w_res_class;
            frame_count <= r_best_found ? r_best_cnt : '0;
            r_cand      <= w_res_class;
            r_cand_none <= w_res_none;
            r_run       <= w_run_next;
            if (w_lock_now && !clear_lock) begin
              stable_class  <= w_res_class;
              stable_locked <= 1'b1;
              change_event  <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      // Placed last so it overrides any lock taken in the same cycle
      if (clear_lock) begin
        stable_locked <= 1'b0;
        r_run         <= '0;
      end
    end
  end

endmodule
`default_nettype wire
